// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, FSM state encodings and channel widths.
package axi4_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // A single register still needs a 1-bit index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Maps a byte address onto a register index and flags whether it hits the bank.
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                    NUM_REGS  = 8,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    localparam int                   IDX_W     = idx_width(NUM_REGS)
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]      index,
    output logic                  in_range
);

    logic [AXI_ADDR_W-1:0] offset;
    logic                  unused_lsbs;

    assign offset = addr - BASE_ADDR;

    // Below-base addresses wrap to a huge offset, but are rejected explicitly anyway.
    assign in_range    = (addr >= BASE_ADDR) && (offset < AXI_ADDR_W'(NUM_REGS * 4));
    assign index       = offset[IDX_W+1:2];
    assign unused_lsbs = ^offset[1:0];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS byte-writable 32-bit registers with independent
// read and write engines, exported flat with per-register write pulses.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int                    NUM_REGS  = 8,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AXI_ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [AXI_DATA_W-1:0]          S_AXI_WDATA,
    input  logic [AXI_DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [AXI_ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [AXI_DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*AXI_DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int NBYTE = AXI_DATA_W / 8;

    logic [NUM_REGS-1:0][AXI_DATA_W-1:0] regs;

    wr_state_t             w_state, w_next;
    logic                  aw_held, w_held, aw_held_n, w_held_n;
    logic                  aw_hs, w_hs, commit;
    logic [AXI_ADDR_W-1:0] aw_addr_q, cur_awaddr;
    logic [AXI_DATA_W-1:0] w_data_q, cur_wdata;
    logic [NBYTE-1:0]      w_strb_q, cur_wstrb;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    resp_t                 bresp_q;

    rd_state_t             r_state, r_next;
    logic                  ar_hs;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_in_range;
    resp_t                 rresp_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit may happen on the same edge a channel handshakes, so bypass the latch.
    assign cur_awaddr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign cur_wdata  = w_held ? w_data_q : S_AXI_WDATA;
    assign cur_wstrb  = w_held ? w_strb_q : S_AXI_WSTRB;

    axi4_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_decode (
        .addr     (cur_awaddr),
        .index    (w_idx),
        .in_range (w_in_range)
    );

    axi4_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_rd_decode (
        .addr     (S_AXI_ARADDR),
        .index    (r_idx),
        .in_range (r_in_range)
    );

    always_comb begin
        w_next    = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        commit    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) aw_held_n = 1'b1;
                if (w_hs)  w_held_n  = 1'b1;
                if (aw_held_n && w_held_n) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_next    = W_IDLE;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            bresp_q       <= OKAY;
        end else begin
            w_state <= w_next;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            S_AXI_AWREADY <= (w_next == W_IDLE) && !aw_held_n;
            S_AXI_WREADY  <= (w_next == W_IDLE) && !w_held_n;
            S_AXI_BVALID  <= (w_next == W_RESP);
            if (commit) bresp_q <= w_in_range ? OKAY : SLVERR;
        end
    end

    assign S_AXI_BRESP = bresp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && w_in_range) begin
                wr_pulse[w_idx] <= 1'b1;
                for (int b = 0; b < NBYTE; b++)
                    if (cur_wstrb[b]) regs[w_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign reg_out = regs;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // regs is sampled before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            rresp_q       <= OKAY;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            S_AXI_RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                S_AXI_RDATA <= r_in_range ? regs[r_idx] : '0;
                rresp_q     <= r_in_range ? OKAY : SLVERR;
            end
        end
    end

    assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: transaction tasks drive the bus and keep a
// register-array model; a per-cycle monitor compares reg_out/wr_pulse against it.
module tb_axi4_lite_slave_regs;

    localparam int          NUM_REGS = 8;
    localparam logic [31:0] BASE     = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [31:0]            S_AXI_AWADDR = '0;
    logic                   S_AXI_AWVALID = 1'b0;
    logic                   S_AXI_AWREADY;
    logic [31:0]            S_AXI_WDATA = '0;
    logic [3:0]             S_AXI_WSTRB = '0;
    logic                   S_AXI_WVALID = 1'b0;
    logic                   S_AXI_WREADY;
    logic [1:0]             S_AXI_BRESP;
    logic                   S_AXI_BVALID;
    logic                   S_AXI_BREADY = 1'b0;
    logic [31:0]            S_AXI_ARADDR = '0;
    logic                   S_AXI_ARVALID = 1'b0;
    logic                   S_AXI_ARREADY;
    logic [31:0]            S_AXI_RDATA;
    logic [1:0]             S_AXI_RRESP;
    logic                   S_AXI_RVALID;
    logic                   S_AXI_RREADY = 1'b0;
    logic [NUM_REGS*32-1:0] reg_out;
    logic [NUM_REGS-1:0]    wr_pulse;

    int                     checks = 0;
    int                     errors = 0;
    logic [31:0]            model [NUM_REGS];
    logic [NUM_REGS-1:0]    exp_pulse = '0;
    logic [NUM_REGS*32-1:0] flat;
    logic [31:0]            rd;
    logic [1:0]             rs, bs;

    axi4_lite_slave_regs #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < NUM_REGS * 4);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Per-cycle monitor: register image, write pulses and the one-outstanding rule.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) flat[32*k +: 32] = model[k];
            checks++;
            if (reg_out !== flat) begin
                errors++;
                $display("FAIL reg_out actual=%h required=%h t=%0t", reg_out, flat, $time);
            end
            chk("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
            if (S_AXI_BVALID) chk("ready_during_b", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
            if (S_AXI_RVALID) chk("arready_during_r", 64'(S_AXI_ARREADY), 0);
        end
    end

    // Call at posedge+1. aw_dly/w_dly delay each channel's VALID; b_dly holds BREADY low.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] er;
        aw_done = 0; w_done = 0; cyc = 0;
        er = in_rng(addr) ? 2'b00 : 2'b10;
        resp = 2'bxx;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 1'b0;
        while (!(aw_done && w_done)) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            chk("b_before_both", 64'(S_AXI_BVALID), 0);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
            if (cyc > 40) begin
                checks++; errors++;
                $display("FAIL wr_handshake_timeout actual=none required=handshake addr=%h", addr);
                S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
                return;
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        if (in_rng(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx_of(addr)][8*b +: 8] = data[8*b +: 8];
            exp_pulse = '0;
            exp_pulse[idx_of(addr)] = 1'b1;
        end
        S_AXI_BREADY = (b_dly == 0);
        @(negedge clk);
        resp = S_AXI_BRESP;
        chk("bvalid", 64'(S_AXI_BVALID), 1);
        chk("bresp", 64'(S_AXI_BRESP), 64'(er));
        @(posedge clk); #1;
        exp_pulse = '0;
        for (int i = 1; i <= b_dly; i++) begin
            S_AXI_BREADY = (i == b_dly);
            @(negedge clk);
            chk("bvalid_hold", 64'(S_AXI_BVALID), 1);
            chk("bresp_hold", 64'(S_AXI_BRESP), 64'(er));
            chk("wready_hold", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", 64'(S_AXI_BVALID), 0);
        chk("wready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge clk); #1;
    endtask

    // Expected data is the model as it stood before the AR handshake edge.
    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int cyc;
        logic [31:0] ed;
        logic [1:0] er;
        hs = 0; cyc = 0; ed = '0;
        er = in_rng(addr) ? 2'b00 : 2'b10;
        data = 'x; resp = 2'bxx;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = (r_dly == 0);
        while (!hs) begin
            @(negedge clk);
            if (S_AXI_ARREADY) begin
                hs = 1;
                ed = in_rng(addr) ? model[idx_of(addr)] : 32'h0;
            end
            @(posedge clk); #1;
            cyc++;
            if (!hs && cyc > 40) begin
                checks++; errors++;
                $display("FAIL rd_handshake_timeout actual=none required=handshake addr=%h", addr);
                S_AXI_ARVALID = 1'b0;
                return;
            end
        end
        S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        chk("rvalid", 64'(S_AXI_RVALID), 1);
        chk("rdata", 64'(S_AXI_RDATA), 64'(ed));
        chk("rresp", 64'(S_AXI_RRESP), 64'(er));
        @(posedge clk); #1;
        for (int i = 1; i <= r_dly; i++) begin
            S_AXI_RREADY = (i == r_dly);
            @(negedge clk);
            chk("rvalid_hold", 64'(S_AXI_RVALID), 1);
            chk("rdata_hold", 64'(S_AXI_RDATA), 64'(ed));
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk("rvalid_drop", 64'(S_AXI_RVALID), 0);
        chk("arready_back", 64'(S_AXI_ARREADY), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

        // Reset: outputs low while held, READYs rise on the first edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
        chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        chk("rst_rdata", 64'(S_AXI_RDATA), 0);
        chk("rst_regs", 64'(|reg_out), 0);
        chk("rst_pulse", 64'(wr_pulse), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_pre_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_post_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge clk); #1;

        do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, bs);
        chk("wr1_reg1", 64'(reg_out[63:32]), 32'hDEAD_BEEF);
        chk("wr1_bresp", 64'(bs), 2'b00);
        do_read(32'h04, 0, rd, rs);
        chk("rd1_data", 64'(rd), 32'hDEAD_BEEF);
        chk("rd1_resp", 64'(rs), 2'b00);

        do_write(32'h08, 32'h1122_3344, 4'hF, 0, 0, 0, bs);
        do_write(32'h08, 32'hAABB_CCDD, 4'b0101, 3, 0, 0, bs);
        chk("partial_reg2", 64'(reg_out[95:64]), 32'h11BB_33DD);

        do_write(32'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0, bs);
        chk("oor_bresp", 64'(bs), 2'b10);
        do_read(32'h20, 0, rd, rs);
        chk("oor_rdata", 64'(rd), 0);
        chk("oor_rresp", 64'(rs), 2'b10);

        // Last register, addressed with nonzero low bits.
        do_write(32'h1F, 32'h1234_5678, 4'hF, 1, 0, 0, bs);
        chk("top_reg7", 64'(reg_out[255:224]), 32'h1234_5678);
        do_read(32'h1E, 0, rd, rs);
        chk("top_rdata", 64'(rd), 32'h1234_5678);

        do_write(32'h10, 32'h0A0B_0C0D, 4'hF, 0, 2, 5, bs);
        do_read(32'h10, 5, rd, rs);
        chk("bp_rdata", 64'(rd), 32'h0A0B_0C0D);

        do_write(32'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, bs);
        chk("strb0_reg1", 64'(reg_out[63:32]), 32'hDEAD_BEEF);
        chk("strb0_bresp", 64'(bs), 2'b00);

        do_write(32'h0C, 32'h1, 4'hF, 0, 0, 0, bs);
        fork
            do_write(32'h0C, 32'h2, 4'hF, 0, 0, 0, bs);
            do_read(32'h0C, 0, rd, rs);
        join
        chk("collide_old", 64'(rd), 32'h1);
        do_read(32'h0C, 0, rd, rs);
        chk("collide_new", 64'(rd), 32'h2);

        // Reset with only AW captured: no response, and the stale AW must not survive.
        S_AXI_AWADDR = 32'h04; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        @(negedge clk);
        chk("midrst_bvalid", 64'(S_AXI_BVALID), 0);
        chk("midrst_regs", 64'(|reg_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_write(32'h18, 32'h0000_0055, 4'hF, 3, 0, 0, bs);
        chk("post_rst_reg6", 64'(reg_out[223:192]), 32'h55);
        chk("post_rst_reg1", 64'(reg_out[63:32]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite responder: a memory-mapped bank of NUM_REGS 32-bit read/write registers.
- Serves write transactions (AW/W/B) and read transactions (AR/R) from the team's AXI4-Lite master over the same 32-bit address/data channels.
- Register contents are exported as a flat vector, with per-register write strobes, to drive control logic.
- One outstanding transaction per direction; reads and writes proceed concurrently and independently.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; legal 1..256.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be NUM_REGS*4 aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- S_AXI_AWADDR  in  32  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address accepted
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables; bit i covers WDATA[8i+7:8i]
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data accepted
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  master ready for response
- S_AXI_ARADDR  in  32  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address accepted
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master ready for read data
- reg_out  out  NUM_REGS*32  register contents; reg k at [32k+31:32k]
- wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register k is written

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Every output and all registers reset to 0, including the READY outputs.
- READY outputs first assert on the first clk edge after rst deasserts. If rst asserts mid-transaction, the transaction is abandoned with no B/R response issued.
- Responses: OKAY = 2'b00. SLVERR = 2'b10 when (addr - BASE_ADDR) >= NUM_REGS*4 or addr < BASE_ADDR.
- Address decode: index = (addr - BASE_ADDR) >> 2. addr[1:0] are ignored.
- Write FSM states:
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - W_IDLE -> W_RESP: on the edge where both AW and W are held. On that same edge, in-range writes update only the bytes whose WSTRB bit is 1; BVALID=1 and BRESP are registered.
  - W_RESP: AWREADY=WREADY=0. BVALID and BRESP are held stable until BREADY=1. The B handshake returns to W_IDLE, clears the captured flags, and drops BVALID.
- Write side effects:
  - Out-of-range write: no register changes, BRESP=SLVERR.
  - WSTRB=4'h0 in range: no data change, BRESP=OKAY, wr_pulse still fires.
  - wr_pulse[k] is high for exactly one cycle, the cycle after the commit edge.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_IDLE -> R_DATA: on the AR handshake. On that edge RDATA and RRESP are registered; out-of-range gives RDATA=0 and SLVERR.
  - R_DATA: RVALID=1, ARREADY=0. RDATA and RRESP are stable until RREADY. The handshake returns to R_IDLE.
- Read latency: RVALID asserts one cycle after the AR handshake.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- Back-to-back transactions: after a B or R handshake, the READY outputs reassert the following cycle. Maximum throughput is one write per 2 cycles and one read per 2 cycles.
- Responses never depend on READY combinationally. All AXI outputs are registered.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Write FSM and read FSM state enums.
  - AXI_DATA_W=32 and AXI_ADDR_W=32 constants.
- One sub-module: axi4_lite_addr_decode. It is combinational: inputs addr, BASE_ADDR, NUM_REGS; outputs index and in_range. It is instantiated once for writes and once for reads.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0. First edge after release -> AWREADY=WREADY=ARREADY=1.
- Write then read, in range: AW=0x04 and W=0xDEADBEEF with WSTRB=F in the same cycle -> BVALID next cycle with BRESP=00, wr_pulse[1] pulses. Then AR=0x04 -> RVALID one cycle later, RDATA=0xDEADBEEF, RRESP=00.
- W before AW, partial strobe: reg2 preloaded 0x11223344. W=0xAABBCCDD with WSTRB=4'b0101, then AW=0x08 three cycles later -> no B until AW arrives; reg_out reg2 = 0x11BB33DD.
- Out of range, NUM_REGS=8: write 0x20 -> BRESP=10 and no reg_out change. Read 0x20 -> RDATA=0, RRESP=10.
- Backpressure: BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout. Same check with RREADY=0: RDATA held.
- Concurrent same address: reg3=0x1, AR=0x0C on the same edge as a write commit of 0x2 to 0x0C -> RDATA=0x1. A subsequent read returns 0x2.
